// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer plus ZERO/WAIT1/ONE/WAIT0 FSM per channel.
// Define BTN_AUTOREPEAT_EN to add a per-channel auto-repeat tick while a button is held.
module btn_debounce #(
    parameter int N_BTN         = 3,
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] db_tick
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("btn_debounce: DB_CYCLES and REPEAT_CYCLES must be 2 or more");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]    state;
        logic [1:0]    state_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          press;
        logic          tick_nx;
        logic          level_q;
        logic          tick_q;

        // Increment only below CNT_MAX, so the counter saturates rather than wraps.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            press    = 1'b0;
            case (state)
                ZERO: begin
                    if (sync2[i]) begin
                        state_nx = WAIT1;
                        cnt_nx   = '0;
                    end
                end
                WAIT1: begin
                    if (!sync2[i]) begin
                        state_nx = ZERO;
                    end else if (cnt == CNT_MAX) begin
                        state_nx = ONE;
                        press    = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ONE: begin
                    if (!sync2[i]) begin
                        state_nx = WAIT0;
                        cnt_nx   = '0;
                    end
                end
                WAIT0: begin
                    if (sync2[i]) begin
                        state_nx = ONE;
                    end else if (cnt == CNT_MAX) begin
                        state_nx = ZERO;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = ZERO;
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES);
        localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rpt;
        logic [RW-1:0] rpt_nx;
        logic          rep;

        // Counts only while staying in ONE; entry to or exit from ONE leaves it at zero.
        always_comb begin
            rpt_nx = '0;
            rep    = 1'b0;
            if (state == ONE && state_nx == ONE) begin
                if (rpt == RPT_MAX) begin
                    rep = 1'b1;
                end else begin
                    rpt_nx = rpt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rpt <= '0;
            else        rpt <= rpt_nx;
        end

        assign tick_nx = press | rep;
`else
        assign tick_nx = press;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ZERO;
                cnt     <= '0;
                level_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state   <= state_nx;
                cnt     <= cnt_nx;
                level_q <= (state_nx == ONE) || (state_nx == WAIT0);
                tick_q  <= tick_nx;
            end
        end

        assign db_level[i] = level_q;
        assign db_tick[i]  = tick_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DB_CYCLES=4, REPEAT_CYCLES=10, N_BTN=3).
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] db_level;
    logic [2:0] db_tick;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  val;
    } ev_t;

    ev_t tq[$];
    ev_t lq[$];

    btn_debounce #(
        .N_BTN(3),
        .DB_CYCLES(4),
        .REPEAT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .db_level(db_level),
        .db_tick(db_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_tick(input int unsigned c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        tq.push_back(e);
    endtask

    task automatic push_lvl(input int unsigned c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        lq.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every nonzero tick and every level change must match the next queued event.
    initial begin : monitor
        logic [2:0] prev;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (db_tick !== 3'b000) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected cyc=%0d got=%b expected none", cyc, db_tick);
                end else begin
                    e = tq.pop_front();
                    if (e.cyc != cyc || e.val !== db_tick) begin
                        errors++;
                        $display("FAIL tick cyc=%0d got=%b expected cyc=%0d val=%b", cyc, db_tick, e.cyc, e.val);
                    end
                end
            end
            if (db_level !== prev) begin
                checks++;
                if (lq.size() == 0) begin
                    errors++;
                    $display("FAIL level_unexpected cyc=%0d got=%b prev=%b", cyc, db_level, prev);
                end else begin
                    e = lq.pop_front();
                    if (e.cyc != cyc || e.val !== db_level) begin
                        errors++;
                        $display("FAIL level cyc=%0d got=%b expected cyc=%0d val=%b", cyc, db_level, e.cyc, e.val);
                    end
                end
            end
            prev = db_level;
        end
    end

    task automatic check_now(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    initial begin : stim
        int unsigned c;
        int unsigned r;
        rst_n   = 1'b0;
        btn_raw = '0;
        wait_cycles(3);
        check_now("reset_level", db_level, 3'b000);
        check_now("reset_tick", db_tick, 3'b000);
        rst_n = 1'b1;
        wait_cycles(3);

        // Clean press on bit0, held 48 cycles
        c = cyc;
        btn_raw[0] = 1'b1;
        push_tick(c + 7, 3'b001);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 1; k <= 4; k++) push_tick(c + 7 + 10 * k, 3'b001);
`endif
        push_lvl(c + 7, 3'b001);
        wait_cycles(48);
        btn_raw[0] = 1'b0;
        push_lvl(cyc + 7, 3'b000);
        wait_cycles(12);

        // Short pulse of 3 cycles: rejected
        btn_raw[0] = 1'b1;
        wait_cycles(3);
        btn_raw[0] = 1'b0;
        wait_cycles(12);

        // Accepted press, 2-cycle low glitch, then sustained release
        c = cyc;
        btn_raw[0] = 1'b1;
        push_tick(c + 7, 3'b001);
        push_lvl(c + 7, 3'b001);
        wait_cycles(9);
        btn_raw[0] = 1'b0;
        wait_cycles(2);
        btn_raw[0] = 1'b1;
        wait_cycles(4);
        btn_raw[0] = 1'b0;
        push_lvl(cyc + 7, 3'b000);
        wait_cycles(12);

        // Simultaneous press on bits 0 and 2
        c = cyc;
        btn_raw = 3'b101;
        push_tick(c + 7, 3'b101);
        push_lvl(c + 7, 3'b101);
        wait_cycles(10);
        btn_raw = 3'b000;
        push_lvl(c + 17, 3'b000);
        wait_cycles(12);

        // Reset during bit1 WAIT1 while bit0 is accepted; bit1 held through release
        c = cyc;
        btn_raw[0] = 1'b1;
        push_tick(c + 7, 3'b001);
        push_lvl(c + 7, 3'b001);
        wait_cycles(8);
        btn_raw[1] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        push_lvl(cyc, 3'b000);
        rst_n = 1'b0;
        #1;
        check_now("async_reset_level", db_level, 3'b000);
        check_now("async_reset_tick", db_tick, 3'b000);
        btn_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        push_tick(r + 7, 3'b010);
        push_lvl(r + 7, 3'b010);
        wait_cycles(9);
        btn_raw[1] = 1'b0;
        push_lvl(cyc + 7, 3'b000);
        wait_cycles(14);

        checks++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL tick_missing got=%0d pending expected=0", tq.size());
        end
        checks++;
        if (lq.size() != 0) begin
            errors++;
            $display("FAIL level_missing got=%0d pending expected=0", lq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
